// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-register slice: datapath width, reset PC,
// bubble instruction and register-index width.
// Optional feature macro used by the top: PIPE_PERF_CNT_EN (stall/flush counters).
package pipe_pkg;

  // Datapath width for PC, instructions and operands
  localparam int XLEN = 32;

  // Register-file index width (32 architectural registers)
  localparam int REGIDX_W = 5;

  // Default width of the opaque ID/EX control payload
  localparam int CTRL_W = 8;

  // Fetch address after reset
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // addi x0,x0,0 : architecturally inert filler for IF/ID on reset/squash
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/pipe_en_clr_reg.sv
// Purpose: generic pipeline register with sync reset, load enable and clear-to-bubble.
// Latency: 1 cycle from d to q when enabled.
// Backpressure: en=0 holds q (beats clr); clr loads CLR_VAL; reset beats everything.
module pipe_en_clr_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Register update: reset first, then hold when disabled, then clear, then load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RST_VAL;
    end else if (en) begin
      if (clr) begin
        r_q <= CLR_VAL;
      end else begin
        r_q <= d;
      end
    end
  end

  assign q = r_q;

endmodule : pipe_en_clr_reg

// File: rtl/pipe_stage_ctrl.sv
// Purpose: PC, IF/ID and ID/EX registers with stall/flush/redirect; E fields feed hazard logic.
// Latency: instrF->instrD 1 cycle, D fields->E fields 1 cycle; all outputs registered.
// Backpressure: stallF holds PC, stallD holds IF/ID (even over pcsrcD), flushE bubbles ID/EX.
// Optional: define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_stage_ctrl #(
  parameter int                XLEN      = pipe_pkg::XLEN,
  parameter int                CTRL_W    = pipe_pkg::CTRL_W,
  parameter logic [XLEN-1:0]   RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [XLEN-1:0]   NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stallF,
  input  logic                          stallD,
  input  logic                          flushE,
  input  logic                          pcsrcD,
  input  logic [XLEN-1:0]               pcnextF,
  input  logic [XLEN-1:0]               instrF,
  output logic [XLEN-1:0]               pcF,
  output logic [XLEN-1:0]               instrD,
  output logic [XLEN-1:0]               pcplus4D,
  output logic                          validD,
  input  logic [XLEN-1:0]               rd1D,
  input  logic [XLEN-1:0]               rd2D,
  input  logic [XLEN-1:0]               immD,
  input  logic [pipe_pkg::REGIDX_W-1:0] rsD,
  input  logic [pipe_pkg::REGIDX_W-1:0] rtD,
  input  logic [pipe_pkg::REGIDX_W-1:0] writeregD,
  input  logic                          regwriteD,
  input  logic                          memtoregD,
  input  logic                          memwriteD,
  input  logic [CTRL_W-1:0]             ctrlD,
  output logic [XLEN-1:0]               rd1E,
  output logic [XLEN-1:0]               rd2E,
  output logic [XLEN-1:0]               immE,
  output logic [pipe_pkg::REGIDX_W-1:0] rsE,
  output logic [pipe_pkg::REGIDX_W-1:0] rtE,
  output logic [pipe_pkg::REGIDX_W-1:0] writeregE,
  output logic                          regwriteE,
  output logic                          memtoregE,
  output logic                          memwriteE,
  output logic [CTRL_W-1:0]             ctrlE,
  output logic                          validE,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   flush_cnt
);

  localparam int RW = pipe_pkg::REGIDX_W;

  // ID/EX is one flat register: every field shares the same enable/clear,
  // and an all-zero bubble is exactly what hazard compares need to never match.
  localparam int IDEX_W = 3*XLEN + 3*RW + 3 + CTRL_W + 1;

  // ---------------------------------------------------------------- PC
  logic w_pc_en;
  assign w_pc_en = ~stallF;

  pipe_en_clr_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_pc_en),
    .clr   (1'b0),
    .d     (pcnextF),
    .q     (pcF)
  );

  // ---------------------------------------------------------------- IF/ID
  // stallD disables the enable, so a redirect during a stall is ignored:
  // the branch in decode is not resolved while its operands are stalled.
  logic            w_ifid_en;
  logic [XLEN-1:0] w_pcplus4F;

  assign w_ifid_en  = ~stallD;
  assign w_pcplus4F = pcF + XLEN'(4);

  pipe_en_clr_reg #(
    .W       (XLEN),
    .RST_VAL (NOP_INSTR),
    .CLR_VAL (NOP_INSTR)
  ) u_ifid_instr (
    .clk   (clk),
    .reset (reset),
    .en    (w_ifid_en),
    .clr   (pcsrcD),
    .d     (instrF),
    .q     (instrD)
  );

  pipe_en_clr_reg #(
    .W       (XLEN),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_ifid_pcplus4 (
    .clk   (clk),
    .reset (reset),
    .en    (w_ifid_en),
    .clr   (pcsrcD),
    .d     (w_pcplus4F),
    .q     (pcplus4D)
  );

  pipe_en_clr_reg #(
    .W       (1),
    .RST_VAL (1'b0),
    .CLR_VAL (1'b0)
  ) u_ifid_valid (
    .clk   (clk),
    .reset (reset),
    .en    (w_ifid_en),
    .clr   (pcsrcD),
    .d     (1'b1),
    .q     (validD)
  );

  // ---------------------------------------------------------------- ID/EX
  // Never stalled: hazards that need a hold stall D and bubble E instead.
  logic [IDEX_W-1:0] w_idex_d;
  logic [IDEX_W-1:0] w_idex_q;

  assign w_idex_d = {validD, ctrlD, memwriteD, memtoregD, regwriteD,
                     writeregD, rtD, rsD, immD, rd2D, rd1D};

  pipe_en_clr_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_idex_reg (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (flushE),
    .d     (w_idex_d),
    .q     (w_idex_q)
  );

  assign {validE, ctrlE, memwriteE, memtoregE, regwriteE,
          writeregE, rtE, rsE, immE, rd2E, rd1E} = w_idex_q;

  // ---------------------------------------------------------------- counters
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Count decode stalls and squash/bubble cycles; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (stallD) begin
        r_stall_cnt <= r_stall_cnt + 32'h1;
      end
      if (flushE || pcsrcD) begin
        r_flush_cnt <= r_flush_cnt + 32'h1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule : pipe_stage_ctrl

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: reset, free-run fetch, stall+flush,
// decode redirect with and without stall, E-field forwarding indices, counters.
// Counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, flushE, pcsrcD;
  logic [31:0] pcnextF, instrF;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;
  logic [31:0] rd1D, rd2D, immD;
  logic [4:0]  rsD, rtD, writeregD;
  logic        regwriteD, memtoregD, memwriteD;
  logic [7:0]  ctrlD;
  logic [31:0] rd1E, rd2E, immE;
  logic [4:0]  rsE, rtE, writeregE;
  logic        regwriteE, memtoregE, memwriteE;
  logic [7:0]  ctrlE;
  logic        validE;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_inc;
  logic [31:0] pcnext_man;

  int n_checks = 0;
  int n_err    = 0;

  assign pcnextF = pc_inc ? (pcF + 32'd4) : pcnext_man;

  always #5 clk = ~clk;

  pipe_stage_ctrl dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .pcsrcD(pcsrcD), .pcnextF(pcnextF), .instrF(instrF), .pcF(pcF), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD),
    .rsD(rsD), .rtD(rtD), .writeregD(writeregD), .regwriteD(regwriteD),
    .memtoregD(memtoregD), .memwriteD(memwriteD), .ctrlD(ctrlD), .rd1E(rd1E),
    .rd2E(rd2E), .immE(immE), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .ctrlE(ctrlE), .validE(validE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " validE"},    {31'b0, validE},    32'h0);
    chk({tag, " regwriteE"}, {31'b0, regwriteE}, 32'h0);
    chk({tag, " rsE"},       {27'b0, rsE},       32'h0);
    chk({tag, " rtE"},       {27'b0, rtE},       32'h0);
    chk({tag, " writeregE"}, {27'b0, writeregE}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; flushE = 1'b0; pcsrcD = 1'b0;
    pc_inc = 1'b1; pcnext_man = 32'h0; instrF = 32'h0000_0093;
    rd1D = 32'h0; rd2D = 32'h0; immD = 32'h0; rsD = 5'd0; rtD = 5'd0; writeregD = 5'd0;
    regwriteD = 1'b0; memtoregD = 1'b0; memwriteD = 1'b0; ctrlD = 8'h0;

    // ---- reset state
    repeat (3) step();
    chk("rst pcF",      pcF,      32'h0);
    chk("rst instrD",   instrD,   NOP);
    chk("rst pcplus4D", pcplus4D, 32'h0);
    chk("rst validD",   {31'b0, validD}, 32'h0);
    chk("rst ctrlE",    {24'b0, ctrlE},  32'h0);
    chk("rst rd1E",     rd1E,     32'h0);
    chk_bubble("rst");
    chk("rst stall_cnt", stall_cnt, 32'h0);
    chk("rst flush_cnt", flush_cnt, 32'h0);

    // ---- 1: free-running fetch
    reset = 1'b0;
    #1;
    chk("t1 pcF0",    pcF, 32'h0);
    chk("t1 validD0", {31'b0, validD}, 32'h0);
    step();
    chk("t1 pcF4",     pcF, 32'h4);
    chk("t1 validD1",  {31'b0, validD}, 32'h1);
    chk("t1 instrD",   instrD, 32'h0000_0093);
    chk("t1 pcplus4D", pcplus4D, 32'h4);
    step();
    chk("t1 pcF8",     pcF, 32'h8);
    chk("t1 pcplus4D8", pcplus4D, 32'h8);
    chk("t1 validE",   {31'b0, validE}, 32'h1);

    // ---- 2: stall F/D with flushE
    pc_inc = 1'b0; pcnext_man = 32'h10;
    step();
    chk("t2 pcF10", pcF, 32'h10);
    instrF = 32'h00A0_0093;
    step();
    chk("t2 instrD load",   instrD, 32'h00A0_0093);
    chk("t2 pcplus4D load", pcplus4D, 32'h14);
    stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
    instrF = 32'hDEAD_BEEF; pcnext_man = 32'h40;
    regwriteD = 1'b1; rsD = 5'd3; rtD = 5'd4; writeregD = 5'd7; ctrlD = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t2 pcF hold",   pcF, 32'h10);
      chk("t2 instrD hold", instrD, 32'h00A0_0093);
      chk("t2 validD hold", {31'b0, validD}, 32'h1);
      chk("t2 ctrlE",      {24'b0, ctrlE}, 32'h0);
      chk_bubble("t2");
    end

    // ---- 3: redirect squashes IF/ID
    stallF = 1'b0; stallD = 1'b0; flushE = 1'b0;
    pcsrcD = 1'b1; instrF = 32'h1111_1111;
    step();
    chk("t3 instrD nop",   instrD, NOP);
    chk("t3 validD",       {31'b0, validD}, 32'h0);
    chk("t3 pcplus4D",     pcplus4D, 32'h0);
    chk("t3 pcF",          pcF, 32'h40);
    pcsrcD = 1'b0; regwriteD = 1'b0; rsD = 5'd0; rtD = 5'd0; writeregD = 5'd0; ctrlD = 8'h0;
    step();
    chk("t3 validE",  {31'b0, validE}, 32'h0);
    chk("t3 regwriteE", {31'b0, regwriteE}, 32'h0);
    chk("t3 instrD next", instrD, 32'h1111_1111);
    chk("t3 validD next", {31'b0, validD}, 32'h1);

    // ---- 4: redirect while stalled is ignored
    pcsrcD = 1'b1; stallD = 1'b1; instrF = 32'h2222_2222;
    step();
    chk("t4 instrD hold", instrD, 32'h1111_1111);
    chk("t4 validD hold", {31'b0, validD}, 32'h1);

    // ---- 5: D fields reach E
    pcsrcD = 1'b0; stallD = 1'b0;
    regwriteD = 1'b1; memtoregD = 1'b1; writeregD = 5'd5; rsD = 5'd3; rtD = 5'd4;
    rd1D = 32'hAAAA_0001; rd2D = 32'h5555_0002; immD = 32'hFFFF_FFF0; ctrlD = 8'h5A;
    step();
    chk("t5 writeregE", {27'b0, writeregE}, 32'd5);
    chk("t5 rsE",       {27'b0, rsE}, 32'd3);
    chk("t5 rtE",       {27'b0, rtE}, 32'd4);
    chk("t5 regwriteE", {31'b0, regwriteE}, 32'h1);
    chk("t5 memtoregE", {31'b0, memtoregE}, 32'h1);
    chk("t5 memwriteE", {31'b0, memwriteE}, 32'h0);
    chk("t5 rd1E",      rd1E, 32'hAAAA_0001);
    chk("t5 rd2E",      rd2E, 32'h5555_0002);
    chk("t5 immE",      immE, 32'hFFFF_FFF0);
    chk("t5 ctrlE",     {24'b0, ctrlE}, 32'h5A);
    chk("t5 validE",    {31'b0, validE}, 32'h1);

    // ---- reset in the middle of a stall
    regwriteD = 1'b0; memtoregD = 1'b0;
    stallF = 1'b1; stallD = 1'b1; reset = 1'b1; pcnext_man = 32'h80;
    step();
    chk("rs pcF",    pcF, 32'h0);
    chk("rs validD", {31'b0, validD}, 32'h0);
    chk("rs instrD", instrD, NOP);
    chk("rs validE", {31'b0, validE}, 32'h0);

    // ---- 6: performance counters
    reset = 1'b0;
    repeat (3) step();
    chk("t6 pcF held", pcF, 32'h0);
    stallF = 1'b0; stallD = 1'b0; flushE = 1'b1; pcsrcD = 1'b1;
    step();
    pcsrcD = 1'b0;
    step();
    flushE = 1'b0;
    step();
`ifdef PIPE_PERF_CNT_EN
    chk("t6 stall_cnt", stall_cnt, 32'd3);
    chk("t6 flush_cnt", flush_cnt, 32'd2);
`else
    chk("t6 stall_cnt", stall_cnt, 32'd0);
    chk("t6 flush_cnt", flush_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pipe_stage_ctrl
